// File: rtl/crc_table_sequencer.sv
// Table-driven reflected CRC-32 engine: one table read per input byte on a
// read-only memory port, folded into the running CRC, result pulsed in DONE.
module crc_table_sequencer #(
  parameter int               ADDR_W     = 12,
  parameter logic [ADDR_W-1:0] TABLE_BASE = '0,
  parameter logic [31:0]      INIT_VALUE = 32'hFFFF_FFFF,
  parameter logic [31:0]      XOR_OUT    = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  input  logic [31:0]       mem_readdata,
  output logic [31:0]       crc_out,
  output logic              crc_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_LOOKUP,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [31:0]       r_crc;
  logic [7:0]        r_idx;
  logic              r_last;
  logic              r_busy;
  logic              r_in_ready;
  logic              r_mem_cs;
  logic [31:0]       r_crc_out;
  logic              r_crc_valid;

  logic [7:0]        w_idx_next;
  logic [31:0]       w_crc_fold;
  logic [ADDR_W-1:0] w_lookup_addr;

  assign w_idx_next    = r_crc[7:0] ^ in_data;
  assign w_crc_fold    = mem_readdata ^ {8'h00, r_crc[31:8]};
  // Unsigned add in ADDR_W bits: a table placed near the top of memory wraps to 0.
  assign w_lookup_addr = TABLE_BASE + {{(ADDR_W-8){1'b0}}, r_idx};

  // Outputs are registered alongside the state so they are set for the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_crc       <= '0;
      r_idx       <= '0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_mem_cs    <= 1'b0;
      r_crc_out   <= '0;
      r_crc_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every branch reads the pre-edge r_crc.
      r_crc_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_crc      <= INIT_VALUE;
            r_state    <= S_ACCEPT;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
          end
        end
        S_ACCEPT: begin
          if (in_valid) begin
            r_idx      <= w_idx_next;
            r_last     <= in_last;
            r_state    <= S_LOOKUP;
            r_in_ready <= 1'b0;
            r_mem_cs   <= 1'b1;
          end
        end
        S_LOOKUP: begin
          r_state  <= S_UPDATE;
          r_mem_cs <= 1'b0;
        end
        S_UPDATE: begin
          r_crc <= w_crc_fold;
          if (r_last) begin
            r_state     <= S_DONE;
            r_crc_out   <= w_crc_fold ^ XOR_OUT;
            r_crc_valid <= 1'b1;
          end else begin
            r_state    <= S_ACCEPT;
            r_in_ready <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_in_ready <= 1'b0;
          r_mem_cs   <= 1'b0;
        end
      endcase
    end
  end

  assign busy           = r_busy;
  assign in_ready       = r_in_ready;
  assign mem_chipselect = r_mem_cs;
  assign mem_address    = r_mem_cs ? w_lookup_addr : TABLE_BASE;
  assign crc_out        = r_crc_out;
  assign crc_valid      = r_crc_valid;

endmodule

// File: tb/tb_crc_table_sequencer.sv
// Randomized bench for crc_table_sequencer against a bitwise CRC-32 model,
// with the table placed so that it wraps around the top of the address space.
module tb_crc_table_sequencer;

  localparam int          ADDR_W = 12;
  localparam logic [11:0] BASE   = 12'hF80;
  localparam logic [31:0] POLY   = 32'hEDB8_8320;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [11:0] mem_address;
  logic        mem_chipselect;
  logic [31:0] mem_readdata;
  logic [31:0] crc_out;
  logic        crc_valid;

  crc_table_sequencer #(
    .ADDR_W    (ADDR_W),
    .TABLE_BASE(BASE),
    .INIT_VALUE(32'hFFFF_FFFF),
    .XOR_OUT   (32'hFFFF_FFFF)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .busy          (busy),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .mem_address   (mem_address),
    .mem_chipselect(mem_chipselect),
    .mem_readdata  (mem_readdata),
    .crc_out       (crc_out),
    .crc_valid     (crc_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int cs_cnt = 0;
  int valid_cnt = 0;
  logic [11:0] addr_q[$];
  logic [31:0] mem [4096];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Bit-serial reflected CRC-32 update, independent of any table.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  // Synchronous RAM, one-cycle latency; garbage when not selected.
  always @(posedge clk) begin
    if (mem_chipselect) mem_readdata <= mem[mem_address];
    else                mem_readdata <= $urandom;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_chipselect) begin
      cs_cnt++;
      addr_q.push_back(mem_address);
    end
    if (crc_valid) valid_cnt++;
    if (in_ready) check("rdy_only_accept", {29'h0, busy, mem_chipselect, crc_valid}, 32'h4);
  end

  task automatic run_msg(input logic [7:0] msg[$], input int gap_mode, input bit start_in_accept,
                         input bit start_in_done, input bit use_known, input logic [31:0] known);
    logic [31:0] c, exp_out, prev_out;
    logic [11:0] exp_addr[$];
    logic [7:0]  idx;
    int n, g, gsum, t0, cs_base, lat;
    bit hold_ok, ok;
    n = msg.size();
    c = 32'hFFFF_FFFF;
    gsum = 0;
    hold_ok = 1'b1;
    for (int k = 0; k < n; k++) begin
      idx = c[7:0] ^ msg[k];
      exp_addr.push_back(BASE + {4'h0, idx});
      c = crc_step(c, msg[k]);
    end
    exp_out  = c ^ 32'hFFFF_FFFF;
    prev_out = crc_out;
    cs_base  = cs_cnt;
    addr_q.delete();

    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      g = (gap_mode < 0) ? int'($urandom_range(0, 3)) : gap_mode;
      gsum += g;
      if (g > 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        ok = 1'b0;
        for (int w = 0; w < 50 && !ok; w++) begin
          @(negedge clk);
          if (in_ready) ok = 1'b1;
        end
        if (!ok) check("wait_ready", 32'(ok), 32'h1);
        if (start_in_accept) start = 1'b1;
        repeat (g) @(posedge clk);
        #1;
        start = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = msg[k];
      in_last  = (k == n - 1);
      ok = 1'b0;
      for (int w = 0; w < 50 && !ok; w++) begin
        @(negedge clk);
        if (crc_out !== prev_out) hold_ok = 1'b0;
        if (in_ready) ok = 1'b1;
      end
      if (!ok) check("xfer_timeout", 32'(ok), 32'h1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;

    ok = 1'b0;
    for (int w = 0; w < 50 && !ok; w++) begin
      @(negedge clk);
      if (crc_valid) ok = 1'b1;
      else if (crc_out !== prev_out) hold_ok = 1'b0;
    end
    check("valid_seen", 32'(ok), 32'h1);
    lat = cyc - t0 + 1;
    check("latency", 32'(lat), 32'(3 * n + 1 + gsum));
    check("crc_out", crc_out, exp_out);
    if (use_known) check("crc_known", crc_out, known);
    check("crc_hold", 32'(hold_ok), 32'h1);
    check("cs_cycles", 32'(cs_cnt - cs_base), 32'(n));
    for (int k = 0; k < n; k++)
      check("lookup_addr", (k < addr_q.size()) ? 32'(addr_q[k]) : 32'hDEAD, 32'(exp_addr[k]));

    if (start_in_done) begin
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    @(negedge clk);
    check("busy_fall", 32'(busy), 32'h0);
    check("valid_pulse", 32'(crc_valid), 32'h0);
  endtask

  initial begin
    logic [7:0] m9[$];
    logic [7:0] msg[$];
    logic [31:0] first_out;
    int k, ncs, vbase;
    bit hit;
    m9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    for (int i = 0; i < 256; i++) mem[BASE + 12'(i)] = crc_step(32'h0, 8'(i));

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h0);
    check("rst_cs", 32'(mem_chipselect), 32'h0);
    check("rst_addr", 32'(mem_address), 32'(BASE));
    check("rst_crc_out", crc_out, 32'h0);
    check("rst_valid", 32'(crc_valid), 32'h0);
    reset = 1'b0;

    // in_valid in IDLE consumes nothing.
    in_valid = 1'b1; in_last = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_cs", 32'(cs_cnt), 32'h0);
    in_valid = 1'b0; in_last = 1'b0;

    run_msg(m9, 0, 1'b0, 1'b0, 1'b1, 32'hCBF4_3926);
    msg = '{8'h00};
    run_msg(msg, 0, 1'b0, 1'b0, 1'b1, 32'hD202_EF8D);
    check("wrap_addr", (addr_q.size() > 0) ? 32'(addr_q[0]) : 32'hDEAD, 32'h07F);
    run_msg(m9, 5, 1'b1, 1'b0, 1'b1, 32'hCBF4_3926);

    // Reset during LOOKUP of the fourth byte.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    in_valid = 1'b1; in_last = 1'b0; in_data = m9[0];
    k = 0; ncs = 0; hit = 1'b0;
    for (int c = 0; c < 60 && !hit; c++) begin
      @(negedge clk);
      if (mem_chipselect) begin
        ncs++;
        if (ncs == 4) hit = 1'b1;
      end
      if (!hit && in_ready) begin
        @(posedge clk);
        #1;
        k++;
        in_data = m9[k];
      end
    end
    check("rst_reach_lookup4", 32'(hit), 32'h1);
    vbase = valid_cnt;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_ready", 32'(in_ready), 32'h0);
    check("mid_rst_cs", 32'(mem_chipselect), 32'h0);
    check("mid_rst_addr", 32'(mem_address), 32'(BASE));
    check("mid_rst_crc_out", crc_out, 32'h0);
    check("mid_rst_valid", 32'(crc_valid), 32'h0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("no_valid_after_rst", 32'(valid_cnt), 32'(vbase));

    // Start in DONE is ignored; next message starts in the very next IDLE cycle.
    run_msg(m9, 0, 1'b0, 1'b1, 1'b1, 32'hCBF4_3926);
    first_out = crc_out;
    msg = '{8'hA5, 8'h5A, 8'h00, 8'hFF};
    run_msg(msg, -1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("second_differs", 32'(crc_out != first_out), 32'h1);

    for (int t = 0; t < 8; t++) begin
      msg.delete();
      for (int i = 0; i < int'($urandom_range(1, 12)); i++) msg.push_back(8'($urandom));
      run_msg(msg, -1, t[0], t[1], 1'b0, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
